// File: rtl/uart_rx_fifo.sv
// UART receiver (8N1, or 8E1 when UART_RX_PARITY_EN is defined) feeding a
// first-word-fall-through receive FIFO with sticky frame/overrun/parity flags.
module uart_rx_fifo #(
  parameter int unsigned BAUD_DIV   = 4167,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic       clock,
  input  logic       resetb,
  input  logic       rx_i,
  output logic [7:0] rd_data,
  output logic       rd_valid,
  input  logic       rd_ready,
  output logic [4:0] fifo_count,
  output logic       frame_err,
  output logic       overrun,
  output logic       parity_err,
  input  logic       err_clr
);

  localparam int unsigned PtrW     = $clog2(FIFO_DEPTH);
  localparam logic [15:0] HalfLoad = 16'(BAUD_DIV / 2 - 1);
  localparam logic [15:0] FullLoad = 16'(BAUD_DIV - 1);

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

  logic       rx_meta_q, rx_sync_q, rx_prev_q, armed_q;
  logic [1:0] settle_q;
  logic       fall;

  // Start detection is armed only once the synchronizer has flushed its reset
  // value and seen a real high, so a line held low through reset is ignored.
  always_ff @(posedge clock) begin
    if (!resetb) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
      settle_q  <= 2'b00;
      armed_q   <= 1'b0;
    end else begin
      rx_meta_q <= rx_i;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
      settle_q  <= {settle_q[0], 1'b1};
      if (settle_q[1] && rx_sync_q) armed_q <= 1'b1;
    end
  end

  assign fall = armed_q && rx_prev_q && !rx_sync_q;

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  shift_q, shift_d;
  logic        expire, push, frame_set, parity_set;

  assign expire = (cnt_q == 16'd0);

  always_comb begin
    state_d    = state_q;
    cnt_d      = expire ? cnt_q : cnt_q - 16'd1;
    bit_d      = bit_q;
    shift_d    = shift_q;
    push       = 1'b0;
    frame_set  = 1'b0;
    parity_set = 1'b0;
    unique case (state_q)
      StIdle: begin
        cnt_d = 16'd0;
        if (fall) begin
          state_d = StStart;
          cnt_d   = HalfLoad;
        end
      end
      StStart: begin
        if (expire) begin
          if (rx_sync_q) begin
            state_d = StIdle;
          end else begin
            state_d = StData;
            cnt_d   = FullLoad;
            bit_d   = 3'd0;
          end
        end
      end
      StData: begin
        if (expire) begin
          shift_d = {rx_sync_q, shift_q[7:1]};
          cnt_d   = FullLoad;
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = StParity;
`else
            state_d = StStop;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      StParity: begin
        if (expire) begin
          parity_set = (rx_sync_q != ^shift_q);
          state_d    = StStop;
          cnt_d      = FullLoad;
        end
      end
`endif
      StStop: begin
        // Leave mid-stop-bit so a back-to-back start edge is not missed.
        if (expire) begin
          push      = rx_sync_q;
          frame_set = !rx_sync_q;
          state_d   = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!resetb) begin
      state_q <= StIdle;
      cnt_q   <= 16'd0;
      bit_q   <= 3'd0;
      shift_q <= 8'h00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
    end
  end

  logic [7:0]      mem_q [FIFO_DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [4:0]      count_q;
  logic            full, pop, wr_en, ovr_set;

  assign full    = (count_q == 5'(FIFO_DEPTH));
  assign pop     = rd_valid && rd_ready;
  assign wr_en   = push && (!full || pop);
  assign ovr_set = push && full && !pop;

  always_ff @(posedge clock) begin
    if (wr_en) mem_q[wr_ptr_q] <= shift_q;
  end

  always_ff @(posedge clock) begin
    if (!resetb) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= 5'd0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)   rd_ptr_q <= rd_ptr_q + PtrW'(1);
      count_q <= count_q + 5'(wr_en) - 5'(pop);
    end
  end

  assign rd_valid   = (count_q != 5'd0);
  assign rd_data    = rd_valid ? mem_q[rd_ptr_q] : 8'h00;
  assign fifo_count = count_q;

  // Sticky flags: a same-cycle set takes priority over err_clr.
  logic frame_err_q, overrun_q;

  always_ff @(posedge clock) begin
    if (!resetb) begin
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      frame_err_q <= frame_set | (frame_err_q & ~err_clr);
      overrun_q   <= ovr_set | (overrun_q & ~err_clr);
    end
  end

  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;

`ifdef UART_RX_PARITY_EN
  logic parity_err_q;

  always_ff @(posedge clock) begin
    if (!resetb) parity_err_q <= 1'b0;
    else         parity_err_q <= parity_set | (parity_err_q & ~err_clr);
  end

  assign parity_err = parity_err_q;
`else
  logic unused_parity;
  assign unused_parity = parity_set;
  assign parity_err    = 1'b0;
`endif

endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 SHALL provide parameter BAUD_DIV, default 4167: clock cycles per bit (40 MHz / 9600 baud), legal range 4..65535.
REQ-002 SHALL provide parameter FIFO_DEPTH, default 8: receive FIFO entries, power of two, 2..16.
REQ-003 SHALL provide port clock, input, 1: single clock; all logic on its rising edge.
REQ-004 SHALL provide port resetb, input, 1: reset, synchronous, active-low.
REQ-005 SHALL provide port rx_i, input, 1: asynchronous serial line (mprj_io[5]), idle high.
REQ-006 SHALL provide port rd_data, output, 8: FIFO head byte, valid while rd_valid=1.
REQ-007 SHALL provide port rd_valid, output, 1: FIFO not empty.
REQ-008 SHALL provide port rd_ready, input, 1: consumer pop request.
REQ-009 SHALL provide port fifo_count, output, 5: current FIFO occupancy.
REQ-010 SHALL provide port frame_err, output, 1: sticky stop-bit error.
REQ-011 SHALL provide port overrun, output, 1: sticky byte-dropped-on-full flag.
REQ-012 SHALL provide port parity_err, output, 1: sticky parity error.
REQ-013 SHALL provide port err_clr, input, 1: clears all sticky flags.

Function
REQ-014 SHALL pass rx_i through a 2-flop synchronizer, reset value 1; all sampling uses the synchronized value.
REQ-015 SHALL implement states IDLE, START, DATA, PARITY, STOP, encoded as a single state register.
REQ-016 IDLE: a synchronized 1->0 transition SHALL enter START and load bit counter with BAUD_DIV/2 - 1 (integer division).
REQ-017 START: at counter expiry, line=1 SHALL return to IDLE (glitch rejected, no flag); line=0 SHALL enter DATA with counter BAUD_DIV-1.
REQ-018 DATA: SHALL sample 8 bits at each counter expiry, LSB first, reloading BAUD_DIV-1 after each bit.
REQ-019 After bit 7, SHALL enter PARITY if UART_RX_PARITY_EN is defined, else STOP.
REQ-020 STOP: at counter expiry, line=1 SHALL push the byte; line=0 SHALL set frame_err and discard the byte; both cases SHALL return to IDLE the next cycle (mid-stop-bit), allowing back-to-back frames.
REQ-021 Push SHALL make the byte visible on rd_data/rd_valid exactly one cycle after the stop-bit sample cycle.
REQ-022 FIFO SHALL be first-word-fall-through; pop occurs when rd_valid && rd_ready; rd_ready with rd_valid=0 SHALL have no effect.
REQ-023 Push while full without a same-cycle pop SHALL drop the new byte, set overrun, leave contents unchanged.
REQ-024 Push and pop in the same cycle while full SHALL both be accepted; overrun SHALL NOT set; fifo_count unchanged.
REQ-025 Push and pop in the same cycle while empty: not possible (rd_valid=0); push SHALL proceed normally.
REQ-026 Read/write pointers SHALL wrap modulo FIFO_DEPTH; fifo_count SHALL range 0..FIFO_DEPTH.
REQ-027 err_clr SHALL clear sticky flags one cycle later; a same-cycle set event SHALL win over err_clr.
REQ-028 rd_data SHALL hold its value while rd_valid=1 and no pop occurs.

Reset
REQ-029 resetb=0 at a rising edge SHALL force state IDLE, counters 0, pointers 0, fifo_count 0, rd_valid 0, rd_data 0x00, all sticky flags 0, synchronizer flops 1.
REQ-030 Reset mid-frame SHALL abandon the partial byte; no push, no flag after release.
REQ-031 After release, a line held low SHALL NOT start a frame until a 1->0 transition is observed.

Configuration
REQ-032 Macro UART_RX_PARITY_EN defined: frame is 8E1; PARITY state samples one bit at BAUD_DIV spacing; a mismatch against even parity of the data SHALL set parity_err, and the byte SHALL still be pushed if stop=1.
REQ-033 Macro UART_RX_PARITY_EN undefined: frame is 8N1; PARITY state unreachable; parity_err SHALL be constant 0.

Verification
REQ-034 BAUD_DIV=16, send 0x55 8N1, rd_ready=0 -> rd_valid=1, rd_data=0x55, fifo_count=1, no flags.
REQ-035 BAUD_DIV=16, send 0xA3 with stop bit=0 -> frame_err=1, fifo_count=0; pulse err_clr -> frame_err=0.
REQ-036 BAUD_DIV=16, FIFO_DEPTH=8, send 9 bytes 0x00..0x08 back-to-back, rd_ready=0 -> fifo_count=8, overrun=1, pops return 0x00..0x07 in order.
REQ-037 rx_i low pulse of 5 cycles at BAUD_DIV=16 -> state returns to IDLE, fifo_count=0, no flags.
REQ-038 UART_RX_PARITY_EN defined, send 0x07 with parity bit 0 -> rd_data=0x07 pushed, parity_err=1; parity bit 1 -> parity_err stays 0.
REQ-039 Assert resetb=0 during data bit 4 of 0x3C, release, then send 0x81 -> only 0x81 in FIFO, fifo_count=1.
